// File: rtl/icache_refill_ctrl_if.sv
// Bundles the fetch, icache and memory-read signals of the icache refill
// controller. The controller side uses the master modport; the
// surrounding fetch/cache/memory environment uses the slave modport.
interface icache_refill_ctrl_if #(
   parameter int ADDR_WIDTH  = 64,
   parameter int BLOCK_WIDTH = 512,
   parameter int BEAT_WIDTH  = 64,
   parameter int CNT_WIDTH   = 32
);
   // fetch stage / icache lookup
   logic                   i_fetch_req;
   logic [ADDR_WIDTH-1:0]  i_fetch_addr;
   logic                   i_hit;
   logic                   o_stall;
   logic [ADDR_WIDTH-1:0]  o_cache_addr;
   logic                   o_cache_write_en;
   logic [BLOCK_WIDTH-1:0] o_cache_block;
   // memory read request channel
   logic                   o_mem_req_valid;
   logic                   i_mem_req_ready;
   logic [ADDR_WIDTH-1:0]  o_mem_req_addr;
   // memory read data channel
   logic                   i_mem_data_valid;
   logic                   o_mem_data_ready;
   logic [BEAT_WIDTH-1:0]  i_mem_data;
   logic                   i_mem_data_last;
   logic                   i_mem_error;
   // status
   logic                   o_fault;
   logic [CNT_WIDTH-1:0]   o_miss_count;

   modport master (
      input  i_fetch_req, i_fetch_addr, i_hit, i_mem_req_ready,
             i_mem_data_valid, i_mem_data, i_mem_data_last, i_mem_error,
      output o_stall, o_cache_addr, o_cache_write_en, o_cache_block,
             o_mem_req_valid, o_mem_req_addr, o_mem_data_ready,
             o_fault, o_miss_count
   );

   modport slave (
      output i_fetch_req, i_fetch_addr, i_hit, i_mem_req_ready,
             i_mem_data_valid, i_mem_data, i_mem_data_last, i_mem_error,
      input  o_stall, o_cache_addr, o_cache_write_en, o_cache_block,
             o_mem_req_valid, o_mem_req_addr, o_mem_data_ready,
             o_fault, o_miss_count
   );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Miss-handling controller for a direct-mapped instruction cache.
// On a miss it stalls fetch, requests the block-aligned line from memory,
// assembles the returned beats into one block, writes it into the cache
// with a single-cycle pulse and releases fetch. Malformed or erroring
// bursts abort the refill with a one-cycle fault pulse and no write.
module icache_refill_ctrl #(
   parameter int ADDR_WIDTH  = 64,
   parameter int BLOCK_WIDTH = 512,
   parameter int BEAT_WIDTH  = 64,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                  i_clk,
   input  logic                  i_arst,
   icache_refill_ctrl_if.master  bus
);

   localparam int BEATS      = BLOCK_WIDTH / BEAT_WIDTH;
   localparam int BEAT_IDX_W = $clog2(BEATS);
   localparam int OFFSET_W   = $clog2(BLOCK_WIDTH / 8);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_FILL,
      S_WRITE,
      S_ABORT
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   blk_addr_q, blk_addr_d;
   logic [BEAT_IDX_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic [BLOCK_WIDTH-1:0]  block_q, block_d;
   logic [CNT_WIDTH-1:0]    miss_cnt_q, miss_cnt_d;

   logic miss;
   logic final_beat;

   assign miss       = bus.i_fetch_req & ~bus.i_hit;
   assign final_beat = (beat_cnt_q == BEAT_IDX_W'(BEATS - 1));

   // Control state: FSM, latched block address, beat index and miss count.
   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples the pre-edge values regardless of block ordering.
   always_ff @(posedge i_clk) begin
      if (i_arst) begin
         state_q    <= S_IDLE;
         blk_addr_q <= '0;
         beat_cnt_q <= '0;
         miss_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         blk_addr_q <= blk_addr_d;
         beat_cnt_q <= beat_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   // Block assembly buffer.
   // NOTE: the block data is meaningless until a full burst has landed, so it
   // is deliberately left out of reset; only the control path is reset.
   always_ff @(posedge i_clk) begin
      block_q <= block_d;
   end

   // Next-state logic and outputs for the refill sequence.
   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      blk_addr_d = blk_addr_q;
      beat_cnt_d = beat_cnt_q;
      block_d    = block_q;
      miss_cnt_d = miss_cnt_q;

      bus.o_stall          = 1'b1;
      bus.o_cache_addr     = blk_addr_q;
      bus.o_cache_write_en = 1'b0;
      bus.o_mem_req_valid  = 1'b0;
      bus.o_mem_data_ready = 1'b0;
      bus.o_fault          = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            bus.o_cache_addr = bus.i_fetch_addr;
            bus.o_stall      = miss;
            if (miss) begin
               blk_addr_d = {bus.i_fetch_addr[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
               if (miss_cnt_q != {CNT_WIDTH{1'b1}}) begin
                  miss_cnt_d = miss_cnt_q + 1'b1;
               end
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            bus.o_mem_req_valid = 1'b1;
            if (bus.i_mem_req_ready) begin
               beat_cnt_d = '0;
               state_d    = S_FILL;
            end
         end
         S_FILL: begin
            bus.o_mem_data_ready = 1'b1;
            if (bus.i_mem_data_valid) begin
               block_d[beat_cnt_q*BEAT_WIDTH +: BEAT_WIDTH] = bus.i_mem_data;
               beat_cnt_d = beat_cnt_q + 1'b1;
               // last must coincide exactly with the final beat; error wins
               if (bus.i_mem_error || (bus.i_mem_data_last != final_beat)) begin
                  state_d = S_ABORT;
               end else if (final_beat) begin
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            bus.o_cache_write_en = 1'b1;
            state_d              = S_IDLE;
         end
         S_ABORT: begin
            bus.o_fault = 1'b1;
            state_d     = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.o_mem_req_addr = blk_addr_q;
   assign bus.o_cache_block  = block_q;
   assign bus.o_miss_count   = miss_cnt_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: a table of directed refills,
// randomized refills checked against a burst-outcome model, hand-written
// reset/idle sequences, and a narrow-counter instance for saturation.
module tb_icache_refill_ctrl;

   localparam int AW = 64;
   localparam int BW = 512;
   localparam int DW = 64;
   localparam int CW = 32;

   typedef struct {
      string       name;
      logic [63:0] addr;
      int          req_delay;  // cycles with i_mem_req_ready low
      int          gap;        // idle cycles before every beat
      int          last_at;    // beat index carrying last (8 = never)
      int          err_at;     // beat index carrying error (8 = never)
      bit          redirect;   // change fetch address during the refill
      logic [63:0] base;       // beat i carries base + i
      bit          exp_write;  // expected outcome: write (1) or fault (0)
      logic [63:0] exp_blk;    // expected block-aligned address
   } refill_t;

   logic clk = 1'b0;
   logic arst;
   always #5 clk = ~clk;

   icache_refill_ctrl_if #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .BEAT_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
   icache_refill_ctrl #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .BEAT_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .i_clk  (clk),
      .i_arst (arst),
      .bus    (bus)
   );

   // narrow counter instance, held in a permanent miss/error-abort loop
   icache_refill_ctrl_if #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .BEAT_WIDTH(DW), .CNT_WIDTH(2)) sbus ();
   icache_refill_ctrl #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .BEAT_WIDTH(DW), .CNT_WIDTH(2)) sat_dut (
      .i_clk  (clk),
      .i_arst (arst),
      .bus    (sbus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic [CW-1:0] exp_count = '0;
   int sat_faults = 0;

   always @(negedge clk) begin
      if (!arst && sbus.o_fault) sat_faults++;
   end

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic refill_t mk(input string name, input logic [63:0] addr, input int dly,
                                  input int gap, input int last_at, input int err_at,
                                  input bit redir, input logic [63:0] base,
                                  input bit exp_write, input logic [63:0] exp_blk);
      refill_t r;
      r.name = name; r.addr = addr; r.req_delay = dly; r.gap = gap;
      r.last_at = last_at; r.err_at = err_at; r.redirect = redir; r.base = base;
      r.exp_write = exp_write; r.exp_blk = exp_blk;
      return r;
   endfunction

   // Reference model: how many beats the controller consumes and whether the
   // burst is well-formed (last exactly on beat 7, no error anywhere).
   function automatic int burst_outcome(input refill_t r, output bit wr);
      int  n = 8;
      bit  done = 1'b0;
      wr = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (!done && (i == r.err_at || (i == r.last_at && i < 7))) begin
            n    = i + 1;
            done = 1'b1;
         end
      end
      if (!done) wr = (r.last_at == 7);
      return n;
   endfunction

   function automatic logic [511:0] model_block(input logic [63:0] base);
      logic [511:0] b;
      for (int i = 0; i < 8; i++) b[i*64 +: 64] = base + 64'(i);
      return b;
   endfunction

   task automatic idle_inputs();
      bus.i_fetch_req      = 1'b0;
      bus.i_hit            = 1'b0;
      bus.i_mem_req_ready  = 1'b0;
      bus.i_mem_data_valid = 1'b0;
      bus.i_mem_data       = '0;
      bus.i_mem_data_last  = 1'b0;
      bus.i_mem_error      = 1'b0;
   endtask

   // One complete miss: detection, request phase, burst, write/abort, release.
   task automatic run_refill(input refill_t r);
      bit          wr_unused;
      int          nb;
      logic [63:0] cur_addr;
      nb = burst_outcome(r, wr_unused);
      cur_addr = r.addr;

      @(negedge clk);
      bus.i_fetch_req = 1'b1; bus.i_fetch_addr = r.addr; bus.i_hit = 1'b0;
      #1;
      check({r.name, "/miss_stall"}, bus.o_stall, 1'b1);
      check({r.name, "/idle_lookup_addr"}, bus.o_cache_addr, r.addr);
      if (exp_count != '1) exp_count = exp_count + 1'b1;

      @(negedge clk);
      if (r.redirect) begin
         cur_addr = r.addr ^ 64'h0000_0100_0000_0FC0;
         bus.i_fetch_addr = cur_addr;
      end
      for (int d = 0; d < r.req_delay; d++) begin
         bus.i_mem_req_ready = 1'b0;
         #1;
         check({r.name, "/req_wait"}, {bus.o_mem_req_valid, bus.o_mem_req_addr, bus.o_stall},
               {1'b1, r.exp_blk, 1'b1});
         @(negedge clk);
      end
      bus.i_mem_req_ready = 1'b1;
      #1;
      check({r.name, "/req_accept"}, {bus.o_mem_req_valid, bus.o_mem_req_addr}, {1'b1, r.exp_blk});
      check({r.name, "/miss_count"}, bus.o_miss_count, exp_count);
      @(negedge clk);
      bus.i_mem_req_ready = 1'b0;

      for (int i = 0; i < nb; i++) begin
         for (int g = 0; g < r.gap; g++) begin
            bus.i_mem_data_valid = 1'b0;
            #1;
            check({r.name, "/fill_gap"}, {bus.o_mem_data_ready, bus.o_cache_write_en, bus.o_fault},
                  3'b100);
            @(negedge clk);
         end
         bus.i_mem_data_valid = 1'b1;
         bus.i_mem_data       = r.base + 64'(i);
         bus.i_mem_data_last  = (i == r.last_at);
         bus.i_mem_error      = (i == r.err_at);
         #1;
         check({r.name, "/fill_beat"}, {bus.o_mem_data_ready, bus.o_stall, bus.o_cache_write_en},
               3'b110);
         @(negedge clk);
      end
      bus.i_mem_data_valid = 1'b0;
      bus.i_mem_data_last  = 1'b0;
      bus.i_mem_error      = 1'b0;
      #1;
      check({r.name, "/end_write_en"}, bus.o_cache_write_en, r.exp_write);
      check({r.name, "/end_fault"}, bus.o_fault, !r.exp_write);
      check({r.name, "/end_addr"}, {bus.o_cache_addr, bus.o_stall}, {r.exp_blk, 1'b1});
      if (r.exp_write) begin
         check({r.name, "/block"}, bus.o_cache_block, model_block(r.base));
         bus.i_hit = 1'b1;
      end else begin
         bus.i_fetch_req = 1'b0;
      end

      @(negedge clk);
      #1;
      check({r.name, "/release"},
            {bus.o_stall, bus.o_cache_write_en, bus.o_fault, bus.o_mem_req_valid, bus.o_mem_data_ready},
            5'b0);
      if (r.exp_write) check({r.name, "/post_lookup_addr"}, bus.o_cache_addr, cur_addr);
      bus.i_fetch_req = 1'b0;
      bus.i_hit       = 1'b0;
   endtask

   refill_t tbl[8];

   initial begin
      tbl[0] = mk("cold",      64'h0000_0000_0000_1044, 0, 0, 7, 8, 0, 64'h0, 1, 64'h0000_0000_0000_1040);
      tbl[1] = mk("backpress", 64'hDEAD_BEEF_0000_12FF, 5, 2, 7, 8, 0, 64'hA5A5_0000_0000_0100, 1,
                  64'hDEAD_BEEF_0000_12C0);
      tbl[2] = mk("err_b3",    64'h0000_0000_2000_0008, 1, 0, 7, 3, 0, 64'h11, 0, 64'h0000_0000_2000_0000);
      tbl[3] = mk("retry",     64'h0000_0000_2000_0008, 0, 0, 7, 8, 0, 64'h22, 1, 64'h0000_0000_2000_0000);
      tbl[4] = mk("last_b5",   64'h0000_0000_0000_7FF8, 0, 1, 5, 8, 0, 64'h33, 0, 64'h0000_0000_0000_7FC0);
      tbl[5] = mk("nolast_b7", 64'h0000_0000_0000_8000, 0, 0, 8, 8, 0, 64'h44, 0, 64'h0000_0000_0000_8000);
      tbl[6] = mk("errlast_b7",64'h0000_0000_0000_9030, 2, 0, 7, 7, 0, 64'h55, 0, 64'h0000_0000_0000_9000);
      tbl[7] = mk("redirect",  64'h0000_0000_CAFE_0ABC, 1, 1, 7, 8, 1, 64'h66, 1, 64'h0000_0000_CAFE_0A80);

      // narrow instance: miss forever, every first beat errors
      sbus.i_fetch_req = 1'b1; sbus.i_fetch_addr = 64'h40; sbus.i_hit = 1'b0;
      sbus.i_mem_req_ready = 1'b1; sbus.i_mem_data_valid = 1'b1; sbus.i_mem_data = '0;
      sbus.i_mem_data_last = 1'b0; sbus.i_mem_error = 1'b1;

      // reset
      idle_inputs();
      bus.i_fetch_addr = 64'h0;
      arst = 1'b1;
      repeat (2) @(negedge clk);
      arst = 1'b0;
      #1;
      check("reset/outputs",
            {bus.o_stall, bus.o_cache_write_en, bus.o_fault, bus.o_mem_req_valid, bus.o_mem_data_ready},
            5'b0);
      check("reset/miss_count", bus.o_miss_count, 32'd0);

      // idle: no request means no stall whatever i_hit says; a hit never stalls
      bus.i_fetch_addr = 64'h1234_5678_9ABC_DEF0;
      @(negedge clk); bus.i_fetch_req = 1'b0; bus.i_hit = 1'b0; #1;
      check("idle/noreq_stall", {bus.o_stall, bus.o_cache_addr}, {1'b0, 64'h1234_5678_9ABC_DEF0});
      @(negedge clk); bus.i_fetch_req = 1'b1; bus.i_hit = 1'b1; #1;
      check("idle/hit_stall", bus.o_stall, 1'b0);
      @(negedge clk); #1;
      check("idle/no_request", {bus.o_mem_req_valid, bus.o_stall}, 2'b00);
      check("idle/count_kept", bus.o_miss_count, 32'd0);
      bus.i_fetch_req = 1'b0; bus.i_hit = 1'b0;

      // saturation of the narrow counter after many aborted retries
      repeat (16) @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         repeat (4) @(negedge clk);
         #1;
         check("sat/count_held", sbus.o_miss_count, 2'b11);
      end
      check("sat/retries_seen", (sat_faults >= 6), 1'b1);

      // directed table
      for (int i = 0; i < 8; i++) run_refill(tbl[i]);

      // randomized refills against the model
      for (int i = 0; i < 24; i++) begin
         refill_t r;
         int      sel;
         bit      wr;
         r.name      = $sformatf("rand%0d", i);
         r.addr      = {$urandom, $urandom};
         r.req_delay = $urandom_range(0, 3);
         r.gap       = $urandom_range(0, 2);
         r.base      = {$urandom, $urandom};
         r.redirect  = 1'($urandom_range(0, 1));
         r.last_at   = 7;
         r.err_at    = 8;
         sel = $urandom_range(0, 9);
         if (sel == 6) r.err_at = $urandom_range(0, 7);
         else if (sel == 7) r.last_at = $urandom_range(0, 6);
         else if (sel == 8) r.last_at = 8;
         else if (sel == 9) r.err_at = 7;
         void'(burst_outcome(r, wr));
         r.exp_write = wr;
         r.exp_blk   = r.addr & ~64'h3F;
         run_refill(r);
      end

      // reset in the middle of a burst
      @(negedge clk);
      bus.i_fetch_req = 1'b1; bus.i_fetch_addr = 64'h3008; bus.i_hit = 1'b0;
      @(negedge clk); bus.i_mem_req_ready = 1'b1;
      @(negedge clk); bus.i_mem_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.i_mem_data_valid = 1'b1; bus.i_mem_data = 64'(i);
         @(negedge clk);
      end
      arst = 1'b1; bus.i_mem_data = 64'h4;
      @(negedge clk);
      arst = 1'b0; bus.i_fetch_req = 1'b0;
      exp_count = '0;
      for (int i = 5; i < 9; i++) begin
         bus.i_mem_data = 64'(i);
         bus.i_mem_data_last = (i == 7);
         #1;
         check("rst_fill/outputs",
               {bus.o_stall, bus.o_cache_write_en, bus.o_fault, bus.o_mem_req_valid, bus.o_mem_data_ready},
               5'b0);
         check("rst_fill/miss_count", bus.o_miss_count, exp_count);
         @(negedge clk);
      end
      idle_inputs();

      // a fresh miss after the mid-burst reset counts from zero again
      run_refill(mk("post_reset", 64'h0000_0000_0000_3008, 0, 0, 7, 8, 0, 64'h77, 1,
                    64'h0000_0000_0000_3000));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
